fft_butterfly_sequencer: RTL and testbench

//  Sequences one shared radix-2 DIT butterfly (decimation-in-time) over an in-place N-point FFT held in dual-port RAM.
//  Per stage, issues operand read addresses, the twiddle index, data-valid and delayed write-back strobes/addresses.

---
 rtl/fft_butterfly_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_fft_butterfly_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_sequencer.sv
// fft_butterfly_sequencer
//   Drives one shared radix-2 DIT butterfly over an in-place N-point FFT
//   (N = 2**LOGN) held in a dual-port RAM that is preloaded in bit-reversed order.
//   Each stage issues N/2 butterflies, one per cycle. Every butterfly gets an
//   operand address pair and a twiddle index. The bench-side datapath receives a
//   data-valid strobe and a delayed write-back strobe with its addresses.
//
// Parameters
//   LOGN    log2 of FFT size (>= 2)
//   RD_LAT  RAM read latency in cycles (>= 1). Write-back lands RD_LAT+1 cycles
//           after issue.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      run request, sampled only in IDLE
//   busy       high from the first issue cycle through the last drain cycle
//   done       one-cycle pulse after the final write-back
//   rd_en      read strobe for both RAM ports
//   rd_addr_a  top operand address
//   rd_addr_b  bottom operand address (rd_addr_a + half)
//   tw_idx     twiddle index k, aligned with bf_valid
//   bf_valid   RAM data valid at butterfly inputs
//   wr_en      write strobe for both RAM ports
//   wr_addr_a  write address for butterfly output 0
//   wr_addr_b  write address for butterfly output 1
//   stage      current stage, 0 in IDLE
module fft_butterfly_sequencer #(
  parameter int LOGN   = 3,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [LOGN-1:0]          rd_addr_a,
  output logic [LOGN-1:0]          rd_addr_b,
  output logic [LOGN-2:0]          tw_idx,
  output logic                     bf_valid,
  output logic                     wr_en,
  output logic [LOGN-1:0]          wr_addr_a,
  output logic [LOGN-1:0]          wr_addr_b,
  output logic [$clog2(LOGN)-1:0]  stage
);

  localparam int SW = $clog2(LOGN);
  localparam int DW = $clog2(RD_LAT + 1);

  localparam logic [LOGN-2:0] J_LAST    = '1;
  localparam logic [SW-1:0]   ST_LAST   = SW'(LOGN - 1);
  localparam logic [DW-1:0]   DCNT_LAST = DW'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [LOGN-2:0] j_q, j_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;

  // Delay lines for issue-side values. Index 0 is one cycle after issue.
  logic            v_q [RD_LAT+1];
  logic [LOGN-1:0] a_q [RD_LAT+1];
  logic [LOGN-1:0] b_q [RD_LAT+1];
  logic [LOGN-2:0] k_q [RD_LAT];

  logic            issue;
  logic [LOGN-1:0] half, mask, jx, addr_a, addr_b;
  logic [LOGN-2:0] pos, k;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      stage_q <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          j_d     = '0;
          stage_d = '0;
        end
      end
      S_RUN: begin
        j_d = j_q + 1'b1;
        if (j_q == J_LAST) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DCNT_LAST) begin
          j_d = '0;
          if (stage_q == ST_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            stage_d = stage_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address generation: rd_addr_a is j with a zero bit inserted at bit
  // position 'stage'. This equals (j/half)*2*half + (j mod half) without a
  // divider. Because that bit of rd_addr_a is 0, rd_addr_b = rd_addr_a + half
  // reduces to an OR.
  always_comb begin
    issue  = (state_q == S_RUN);
    half   = LOGN'(1) << stage_q;
    mask   = half - LOGN'(1);
    jx     = {1'b0, j_q};
    addr_a = ((jx & ~mask) << 1) | (jx & mask);
    addr_b = addr_a | half;
    pos    = j_q & mask[LOGN-2:0];
    k      = pos << (ST_LAST - stage_q);
  end

  always_comb begin
    busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
    stage     = stage_q;
    rd_en     = issue;
    rd_addr_a = issue ? addr_a : '0;
    rd_addr_b = issue ? addr_b : '0;
    bf_valid  = v_q[RD_LAT-1];
    tw_idx    = k_q[RD_LAT-1];
    wr_en     = v_q[RD_LAT];
    wr_addr_a = a_q[RD_LAT];
    wr_addr_b = b_q[RD_LAT];
  end

  // Issue-side values are already gated to 0 when rd_en is low. This keeps
  // every delayed copy at 0 whenever its own strobe is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        v_q[i] <= '0;
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        k_q[i] <= '0;
      end
    end else begin
      v_q[0] <= rd_en;
      a_q[0] <= rd_addr_a;
      b_q[0] <= rd_addr_b;
      k_q[0] <= issue ? k : '0;
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        a_q[i] <= a_q[i-1];
        b_q[i] <= b_q[i-1];
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        k_q[i] <= k_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
module tb_fft_butterfly_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic       busy, done, rd_en, bf_valid, wr_en;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_idx;
  logic [1:0] stage;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fft_butterfly_sequencer #(.LOGN(3), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_idx(tw_idx), .bf_valid(bf_valid), .wr_en(wr_en),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .stage(stage)
  );

  // ---------------- system model: RAM + twiddle ROM + butterfly ----------------
  int   mem_re [8];
  int   mem_im [8];
  int   ra_re, ra_im, rb_re, rb_im;
  int   o0_re, o0_im, o1_re, o1_im;
  int   tw_r, tw_i, t_re, t_im;
  logic       ld_en = 1'b0;
  logic [2:0] ld_addr = '0;
  int   ld_re = 0, ld_im = 0;

  // W8^k in Q4.4 (1.0 = 16)
  always_comb begin
    tw_r = 16; tw_i = 0;
    case (tw_idx)
      2'd0: begin tw_r = 16;  tw_i = 0;   end
      2'd1: begin tw_r = 11;  tw_i = -11; end
      2'd2: begin tw_r = 0;   tw_i = -16; end
      default: begin tw_r = -11; tw_i = -11; end
    endcase
    t_re = (rb_re * tw_r - rb_im * tw_i) >>> 4;
    t_im = (rb_re * tw_i + rb_im * tw_r) >>> 4;
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      ra_re <= mem_re[rd_addr_a]; ra_im <= mem_im[rd_addr_a];
      rb_re <= mem_re[rd_addr_b]; rb_im <= mem_im[rd_addr_b];
    end
    if (bf_valid) begin
      o0_re <= ra_re + t_re; o0_im <= ra_im + t_im;
      o1_re <= ra_re - t_re; o1_im <= ra_im - t_im;
    end
    if (ld_en) begin
      mem_re[ld_addr] <= ld_re; mem_im[ld_addr] <= ld_im;
    end else if (wr_en) begin
      mem_re[wr_addr_a] <= o0_re; mem_im[wr_addr_a] <= o0_im;
      mem_re[wr_addr_b] <= o1_re; mem_im[wr_addr_b] <= o1_im;
    end
  end

  // ---------------- expected trace for one run (cycle index = Cn) ----------------
  typedef struct {
    int cyc;
    int a;
    int b;
    int k;
  } issue_t;

  issue_t tbl[12];
  int e_rd[0:23], e_ra[0:23], e_rb[0:23], e_bv[0:23], e_k[0:23];
  int e_wr[0:23], e_wa[0:23], e_wb[0:23], e_busy[0:23], e_done[0:23], e_stg[0:23];

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  task automatic build_expect();
    tbl[0]  = '{1, 0, 1, 0};  tbl[1]  = '{2, 2, 3, 0};
    tbl[2]  = '{3, 4, 5, 0};  tbl[3]  = '{4, 6, 7, 0};
    tbl[4]  = '{7, 0, 2, 0};  tbl[5]  = '{8, 1, 3, 2};
    tbl[6]  = '{9, 4, 6, 0};  tbl[7]  = '{10, 5, 7, 2};
    tbl[8]  = '{13, 0, 4, 0}; tbl[9]  = '{14, 1, 5, 1};
    tbl[10] = '{15, 2, 6, 2}; tbl[11] = '{16, 3, 7, 3};
    for (int c = 0; c < 24; c++) begin
      e_rd[c] = 0; e_ra[c] = 0; e_rb[c] = 0; e_bv[c] = 0; e_k[c] = 0;
      e_wr[c] = 0; e_wa[c] = 0; e_wb[c] = 0;
      e_busy[c] = (c >= 1 && c <= 18) ? 1 : 0;
      e_done[c] = (c == 19) ? 1 : 0;
      e_stg[c]  = (c >= 7 && c <= 12) ? 1 : (c >= 13 && c <= 18) ? 2 : (c == 19) ? -1 : 0;
    end
    foreach (tbl[i]) begin
      e_rd[tbl[i].cyc] = 1;
      e_ra[tbl[i].cyc] = tbl[i].a;
      e_rb[tbl[i].cyc] = tbl[i].b;
      e_bv[tbl[i].cyc + 1] = 1;
      e_k[tbl[i].cyc + 1]  = tbl[i].k;
      e_wr[tbl[i].cyc + 2] = 1;
      e_wa[tbl[i].cyc + 2] = tbl[i].a;
      e_wb[tbl[i].cyc + 2] = tbl[i].b;
    end
  endtask

  // Entered just after the edge that sampled start (edge C0). Compares C1..C20.
  task automatic run_compare(input int base);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("rd_en",     base + c, 32'(rd_en),     e_rd[c]);
      chk("rd_addr_a", base + c, 32'(rd_addr_a), e_ra[c]);
      chk("rd_addr_b", base + c, 32'(rd_addr_b), e_rb[c]);
      chk("bf_valid",  base + c, 32'(bf_valid),  e_bv[c]);
      chk("tw_idx",    base + c, 32'(tw_idx),    e_k[c]);
      chk("wr_en",     base + c, 32'(wr_en),     e_wr[c]);
      chk("wr_addr_a", base + c, 32'(wr_addr_a), e_wa[c]);
      chk("wr_addr_b", base + c, 32'(wr_addr_b), e_wb[c]);
      chk("busy",      base + c, 32'(busy),      e_busy[c]);
      chk("done",      base + c, 32'(done),      e_done[c]);
      if (e_stg[c] >= 0) chk("stage", base + c, 32'(stage), e_stg[c]);
    end
  endtask

  task automatic chk_all_zero(input string tag, input int c);
    chk({tag, "_busy"},  c, 32'(busy), 0);
    chk({tag, "_done"},  c, 32'(done), 0);
    chk({tag, "_rd_en"}, c, 32'(rd_en), 0);
    chk({tag, "_rd_a"},  c, 32'(rd_addr_a), 0);
    chk({tag, "_rd_b"},  c, 32'(rd_addr_b), 0);
    chk({tag, "_tw"},    c, 32'(tw_idx), 0);
    chk({tag, "_bfv"},   c, 32'(bf_valid), 0);
    chk({tag, "_wr_en"}, c, 32'(wr_en), 0);
    chk({tag, "_wr_a"},  c, 32'(wr_addr_a), 0);
    chk({tag, "_wr_b"},  c, 32'(wr_addr_b), 0);
    chk({tag, "_stage"}, c, 32'(stage), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  function automatic logic [2:0] brev(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  task automatic load(input int n, input int re);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = brev(3'(n)); ld_re = re; ld_im = 0;
    @(posedge clk); #1 ld_en = 1'b0;
  endtask

  task automatic run_fft_and_check(input string tag, input int x0, input int xr, input int e0, input int er);
    bit seen;
    for (int n = 0; n < 8; n++) load(n, (n == 0) ? x0 : xr);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 0, 32'(seen), 1);
    @(negedge clk);
    for (int kk = 0; kk < 8; kk++) begin
      chk({tag, "_re"}, kk, mem_re[kk], (kk == 0) ? e0 : er);
      chk({tag, "_im"}, kk, mem_im[kk], 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    build_expect();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset", 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle", 0);

    // full run with a single start pulse: addresses, twiddles, delays, busy/done
    pulse_start();
    run_compare(0);
    repeat (3) @(negedge clk);
    chk("idle_after_run_busy", 0, 32'(busy), 0);

    // start held high throughout: ignored while busy, next run issues at C21
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    run_compare(100);
    @(negedge clk);
    chk("held_rd_en_C21", 121, 32'(rd_en), 1);
    chk("held_rd_a_C21",  121, 32'(rd_addr_a), 0);
    chk("held_rd_b_C21",  121, 32'(rd_addr_b), 1);
    chk("held_stage_C21", 121, 32'(stage), 0);
    start = 1'b0;

    // reset during the second run's issue phase
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_in_run", 0);

    // reset at C9 of a fresh run, restart at C12
    pulse_start();
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst_C10", 10);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    run_compare(12);

    // end-to-end FFT through the RAM/ROM/butterfly model (Q4.4)
    run_fft_and_check("impulse", 16, 0, 16, 16);
    run_fft_and_check("const",   2, 2, 16, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
